// File: rtl/sram_port_arb.sv
// sram_port_arb
// Lets NUM_PORTS single-beat requesters share one single-port synchronous
// SRAM. A grant is a zero-cycle, combinational decision. In fixed priority,
// port 0 is highest, and a port that has waited STARVE_MAX cycles is
// force-granted. In round-robin, the search starts at a rotating pointer.
// Read data comes straight from the SRAM. A RD_LAT-deep pipeline tags
// each returning word with the port that issued the read.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   req_en/req_wr       per-port request strobe and write flag
//   req_addr/byteen/    packed per-port address, byte enables and write
//   req_wrdata          data (port 0 in the LSBs)
//   req_busy            per-port "not accepted this cycle"
//   rd_data/rd_valid    shared read data plus one-hot owner tag
//   sram_*              SRAM macro interface (sram_rdata is the input)
module sram_port_arb #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int ARB_MODE   = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          req_en,
    input  logic [NUM_PORTS-1:0]          req_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_byteen,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wrdata,
    output logic [NUM_PORTS-1:0]          req_busy,
    output logic [DATA_W-1:0]             rd_data,
    output logic [NUM_PORTS-1:0]          rd_valid,
    output logic                          sram_en,
    output logic                          sram_wr,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [DATA_W/8-1:0]           sram_byteen,
    output logic [DATA_W-1:0]             sram_wrdata,
    input  logic [DATA_W-1:0]             sram_rdata
);

    localparam int         BE_W       = DATA_W / 8;
    localparam int         PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [NUM_PORTS-1:0] grant_s;
    logic [NUM_PORTS-1:0] starved_s;
    logic [PTR_W-1:0]     gnt_idx_s;
    logic [PTR_W-1:0]     rr_ptr_r;
    logic [3:0]           wait_cnt_r [NUM_PORTS];
    logic [NUM_PORTS-1:0] rd_pipe_r  [RD_LAT];

    // Starvation flags: only a port that is still requesting counts as starved
    always_comb begin
        starved_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_en[i] && (wait_cnt_r[i] == STARVE_LIM)) begin
                starved_s[i] = 1'b1;
            end else begin
                starved_s[i] = 1'b0;
            end
        end
    end

    // One-hot grant selection (round-robin search or fixed priority with escape)
    always_comb begin
        int  idx;
        logic found;
        grant_s   = '0;
        gnt_idx_s = '0;
        found     = 1'b0;
        idx       = 0;
        if (ARB_MODE == 1) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(rr_ptr_r) + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end else begin
                    idx = idx;
                end
                if (!found && req_en[idx]) begin
                    grant_s[idx] = 1'b1;
                    gnt_idx_s    = PTR_W'(idx);
                    found        = 1'b1;
                end else begin
                    found = found;
                end
            end
        end else begin
            // A starved port beats plain priority; lowest index wins in both passes
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!found && starved_s[k]) begin
                    grant_s[k] = 1'b1;
                    gnt_idx_s  = PTR_W'(k);
                    found      = 1'b1;
                end else begin
                    found = found;
                end
            end
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!found && req_en[k]) begin
                    grant_s[k] = 1'b1;
                    gnt_idx_s  = PTR_W'(k);
                    found      = 1'b1;
                end else begin
                    found = found;
                end
            end
        end
    end

    assign req_busy = req_en & ~grant_s;
    assign rd_data  = sram_rdata;
    assign rd_valid = rd_pipe_r[RD_LAT-1];

    // SRAM request mux: granted port's fields, all zero when idle, full byteen on reads
    always_comb begin
        sram_en     = 1'b0;
        sram_wr     = 1'b0;
        sram_addr   = '0;
        sram_byteen = '0;
        sram_wrdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_s[i]) begin
                sram_en     = 1'b1;
                sram_wr     = req_wr[i];
                sram_addr   = req_addr[i*ADDR_W +: ADDR_W];
                sram_byteen = req_wr[i] ? req_byteen[i*BE_W +: BE_W] : {BE_W{1'b1}};
                sram_wrdata = req_wrdata[i*DATA_W +: DATA_W];
            end else begin
                sram_en = sram_en;
            end
        end
    end

    // Round-robin pointer: moves to one past the granted port, holds when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= '0;
        end else if ((ARB_MODE == 1) && (|grant_s)) begin
            if (gnt_idx_s == PTR_W'(NUM_PORTS - 1)) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= gnt_idx_s + PTR_W'(1);
            end
        end
    end

    // Per-port wait counters: count busy cycles up to STARVE_MAX, clear on grant or drop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wait_cnt_r[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if ((ARB_MODE != 0) || !req_en[i] || grant_s[i]) begin
                    wait_cnt_r[i] <= 4'd0;
                end else if (wait_cnt_r[i] != STARVE_LIM) begin
                    wait_cnt_r[i] <= wait_cnt_r[i] + 4'd1;
                end
            end
        end
    end

    // Read-return tag pipeline: an all-zero entry marks a write or an idle cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < RD_LAT; s++) begin
                rd_pipe_r[s] <= '0;
            end
        end else begin
            rd_pipe_r[0] <= (sram_en && !sram_wr) ? grant_s : '0;
            for (int s = 1; s < RD_LAT; s++) begin
                rd_pipe_r[s] <= rd_pipe_r[s-1];
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arb.sv
module tb_sram_port_arb;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req_en = 3'b000;
    logic [2:0]  req_wr = 3'b000;
    logic [14:0] addr_p [3];
    logic [31:0] sram_rdata = 32'h0;
    logic [44:0] req_addr;
    logic [11:0] req_byteen;
    logic [95:0] req_wrdata;

    logic [3:0]  be_c [3];
    logic [31:0] wd_c [3];

    int n_chk  = 0;
    int n_fail = 0;

    assign req_addr   = {addr_p[2], addr_p[1], addr_p[0]};
    assign req_byteen = {4'h7, 4'h3, 4'h1};
    assign req_wrdata = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};

    logic [2:0]  fx_busy, fx_rdv, rr_busy, rr_rdv, l3_busy, l3_rdv;
    logic [31:0] fx_rdata, rr_rdata, l3_rdata, fx_swd, rr_swd, l3_swd;
    logic        fx_sen, fx_swr, rr_sen, rr_swr, l3_sen, l3_swr;
    logic [14:0] fx_saddr, rr_saddr, l3_saddr;
    logic [3:0]  fx_sbe, rr_sbe, l3_sbe;

    sram_port_arb #(.NUM_PORTS(3), .ADDR_W(15), .DATA_W(32), .RD_LAT(1),
                    .ARB_MODE(0), .STARVE_MAX(4)) u_fx (
        .clk(clk), .reset_n(reset_n), .req_en(req_en), .req_wr(req_wr),
        .req_addr(req_addr), .req_byteen(req_byteen), .req_wrdata(req_wrdata),
        .req_busy(fx_busy), .rd_data(fx_rdata), .rd_valid(fx_rdv),
        .sram_en(fx_sen), .sram_wr(fx_swr), .sram_addr(fx_saddr),
        .sram_byteen(fx_sbe), .sram_wrdata(fx_swd), .sram_rdata(sram_rdata));

    sram_port_arb #(.NUM_PORTS(3), .ADDR_W(15), .DATA_W(32), .RD_LAT(2),
                    .ARB_MODE(1), .STARVE_MAX(4)) u_rr (
        .clk(clk), .reset_n(reset_n), .req_en(req_en), .req_wr(req_wr),
        .req_addr(req_addr), .req_byteen(req_byteen), .req_wrdata(req_wrdata),
        .req_busy(rr_busy), .rd_data(rr_rdata), .rd_valid(rr_rdv),
        .sram_en(rr_sen), .sram_wr(rr_swr), .sram_addr(rr_saddr),
        .sram_byteen(rr_sbe), .sram_wrdata(rr_swd), .sram_rdata(sram_rdata));

    sram_port_arb #(.NUM_PORTS(3), .ADDR_W(15), .DATA_W(32), .RD_LAT(3),
                    .ARB_MODE(0), .STARVE_MAX(4)) u_l3 (
        .clk(clk), .reset_n(reset_n), .req_en(req_en), .req_wr(req_wr),
        .req_addr(req_addr), .req_byteen(req_byteen), .req_wrdata(req_wrdata),
        .req_busy(l3_busy), .rd_data(l3_rdata), .rd_valid(l3_rdv),
        .sram_en(l3_sen), .sram_wr(l3_swr), .sram_addr(l3_saddr),
        .sram_byteen(l3_sbe), .sram_wrdata(l3_swd), .sram_rdata(sram_rdata));

    // 10 ns clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  en;
        logic [2:0]  wr;
        logic [14:0] a0;
        logic [14:0] a1;
        logic [14:0] a2;
        int          gnt;
        logic [2:0]  rdv;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Compare one instance's grant-side outputs against the expected granted port
    task automatic chk_port(input string tag, input int gnt, input logic [2:0] busy_a,
                            input logic en_a, input logic wr_a, input logic [14:0] addr_a,
                            input logic [3:0] be_a, input logic [31:0] wd_a);
        logic [2:0]  oh;
        logic        e_en, e_wr;
        logic [14:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        oh = 3'b000; e_en = 1'b0; e_wr = 1'b0; e_addr = 15'h0; e_be = 4'h0; e_wd = 32'h0;
        if (gnt >= 0) begin
            oh     = 3'b001 << gnt;
            e_en   = 1'b1;
            e_wr   = req_wr[gnt];
            e_addr = addr_p[gnt];
            e_be   = req_wr[gnt] ? be_c[gnt] : 4'hF;
            e_wd   = wd_c[gnt];
        end
        chk({tag, "_busy"},   32'(busy_a), 32'(req_en & ~oh));
        chk({tag, "_sram_en"}, 32'(en_a),   32'(e_en));
        chk({tag, "_sram_wr"}, 32'(wr_a),   32'(e_wr));
        chk({tag, "_addr"},   32'(addr_a), 32'(e_addr));
        chk({tag, "_byteen"}, 32'(be_a),   32'(e_be));
        chk({tag, "_wrdata"}, wd_a,        e_wd);
    endtask

    // Apply one cycle of inputs after the falling edge, then settle before sampling
    task automatic drive(input logic [2:0] en, input logic [2:0] wr,
                         input logic [14:0] x0, input logic [14:0] x1, input logic [14:0] x2);
        @(negedge clk);
        req_en = en;
        req_wr = wr;
        addr_p[0] = x0;
        addr_p[1] = x1;
        addr_p[2] = x2;
        #2;
    endtask

    initial begin
        be_c[0] = 4'h1; be_c[1] = 4'h3; be_c[2] = 4'h7;
        wd_c[0] = 32'h1111_1111; wd_c[1] = 32'hDEAD_BEEF; wd_c[2] = 32'h3333_3333;
        addr_p[0] = 15'h0; addr_p[1] = 15'h0; addr_p[2] = 15'h0;

        // en, wr, a0, a1, a2, granted port, rd_valid (fixed priority, RD_LAT=1)
        tbl[0]  = '{3'b000, 3'b000, 15'h0000, 15'h0000, 15'h0000, -1, 3'b000};
        tbl[1]  = '{3'b011, 3'b000, 15'h0010, 15'h0020, 15'h0000,  0, 3'b000};
        tbl[2]  = '{3'b010, 3'b000, 15'h0000, 15'h0020, 15'h0000,  1, 3'b001};
        tbl[3]  = '{3'b000, 3'b000, 15'h0000, 15'h0000, 15'h0000, -1, 3'b010};
        tbl[4]  = '{3'b000, 3'b000, 15'h0000, 15'h0000, 15'h0000, -1, 3'b000};
        tbl[5]  = '{3'b101, 3'b000, 15'h0100, 15'h0000, 15'h0200,  0, 3'b000};
        tbl[6]  = '{3'b101, 3'b000, 15'h0101, 15'h0000, 15'h0200,  0, 3'b001};
        tbl[7]  = '{3'b101, 3'b000, 15'h0102, 15'h0000, 15'h0200,  0, 3'b001};
        tbl[8]  = '{3'b101, 3'b000, 15'h0103, 15'h0000, 15'h0200,  0, 3'b001};
        tbl[9]  = '{3'b101, 3'b000, 15'h0104, 15'h0000, 15'h0200,  2, 3'b001};
        tbl[10] = '{3'b101, 3'b000, 15'h0104, 15'h0000, 15'h0201,  0, 3'b100};
        tbl[11] = '{3'b000, 3'b000, 15'h0000, 15'h0000, 15'h0000, -1, 3'b001};
        tbl[12] = '{3'b000, 3'b000, 15'h0000, 15'h0000, 15'h0000, -1, 3'b000};
        tbl[13] = '{3'b100, 3'b100, 15'h0000, 15'h0000, 15'h1234,  2, 3'b000};
        tbl[14] = '{3'b110, 3'b010, 15'h0000, 15'h0001, 15'h0002,  1, 3'b000};
        tbl[15] = '{3'b100, 3'b000, 15'h0000, 15'h0000, 15'h0002,  2, 3'b000};
        tbl[16] = '{3'b000, 3'b000, 15'h0000, 15'h0000, 15'h0000, -1, 3'b100};
        tbl[17] = '{3'b111, 3'b000, 15'h0007, 15'h0008, 15'h0009,  0, 3'b000};

        // Reset state
        drive(3'b000, 3'b000, 15'h0, 15'h0, 15'h0);
        chk("rst_fx_rdv", 32'(fx_rdv), 32'h0);
        chk("rst_rr_rdv", 32'(rr_rdv), 32'h0);
        chk("rst_l3_rdv", 32'(l3_rdv), 32'h0);
        chk_port("rst_fx", -1, fx_busy, fx_sen, fx_swr, fx_saddr, fx_sbe, fx_swd);
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven fixed-priority sequence
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].en, tbl[i].wr, tbl[i].a0, tbl[i].a1, tbl[i].a2);
            chk_port($sformatf("fx_row%0d", i), tbl[i].gnt, fx_busy, fx_sen, fx_swr,
                     fx_saddr, fx_sbe, fx_swd);
            chk($sformatf("fx_row%0d_rdv", i), 32'(fx_rdv), 32'(tbl[i].rdv));
        end

        // Round-robin: reset, then all three ports reading for 9 cycles
        @(negedge clk);
        reset_n = 1'b0;
        req_en  = 3'b000;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            drive(3'b111, 3'b000, 15'h0100, 15'h0200, 15'h0300);
            chk_port($sformatf("rr_cyc%0d", k), k % 3, rr_busy, rr_sen, rr_swr,
                     rr_saddr, rr_sbe, rr_swd);
            chk($sformatf("rr_cyc%0d_rdv", k), 32'(rr_rdv),
                (k < 2) ? 32'h0 : (32'h1 << ((k - 2) % 3)));
        end

        // Idle: everything quiet, in-flight reads drain, pointer holds
        for (int j = 0; j < 5; j++) begin
            drive(3'b000, 3'b000, 15'h0, 15'h0, 15'h0);
            chk_port($sformatf("idle_rr%0d", j), -1, rr_busy, rr_sen, rr_swr,
                     rr_saddr, rr_sbe, rr_swd);
            chk_port($sformatf("idle_fx%0d", j), -1, fx_busy, fx_sen, fx_swr,
                     fx_saddr, fx_sbe, fx_swd);
            chk($sformatf("idle_rr%0d_rdv", j), 32'(rr_rdv),
                (j == 0) ? 32'h2 : ((j == 1) ? 32'h4 : 32'h0));
        end
        drive(3'b111, 3'b000, 15'h0100, 15'h0200, 15'h0300);
        chk_port("rr_ptr_wrap", 0, rr_busy, rr_sen, rr_swr, rr_saddr, rr_sbe, rr_swd);

        // RD_LAT=3: write then read of 0x7FFF from port 1
        for (int j = 0; j < 3; j++) begin
            drive(3'b000, 3'b000, 15'h0, 15'h0, 15'h0);
        end
        drive(3'b010, 3'b010, 15'h0, 15'h7FFF, 15'h0);
        chk_port("l3_wr", 1, l3_busy, l3_sen, l3_swr, l3_saddr, l3_sbe, l3_swd);
        chk("l3_wr_be", 32'(l3_sbe), 32'h3);
        drive(3'b010, 3'b000, 15'h0, 15'h7FFF, 15'h0);
        chk_port("l3_rd", 1, l3_busy, l3_sen, l3_swr, l3_saddr, l3_sbe, l3_swd);
        chk("l3_rd_be", 32'(l3_sbe), 32'hF);
        chk("l3_rdv_w1", 32'(l3_rdv), 32'h0);
        drive(3'b000, 3'b000, 15'h0, 15'h0, 15'h0);
        chk("l3_rdv_w2", 32'(l3_rdv), 32'h0);
        drive(3'b000, 3'b000, 15'h0, 15'h0, 15'h0);
        chk("l3_rdv_w3", 32'(l3_rdv), 32'h0);
        drive(3'b000, 3'b000, 15'h0, 15'h0, 15'h0);
        sram_rdata = 32'hCAFE_F00D;
        #1;
        chk("l3_rdv_r3", 32'(l3_rdv), 32'h2);
        chk("l3_rd_data", l3_rdata, 32'hCAFE_F00D);
        drive(3'b000, 3'b000, 15'h0, 15'h0, 15'h0);
        chk("l3_rdv_after", 32'(l3_rdv), 32'h0);

        // Reset one cycle after a port0 read accept on the RR instance (RD_LAT=2)
        drive(3'b001, 3'b000, 15'h0040, 15'h0, 15'h0);
        chk_port("rst_mid_rd", 0, rr_busy, rr_sen, rr_swr, rr_saddr, rr_sbe, rr_swd);
        @(negedge clk);
        reset_n = 1'b0;
        req_en  = 3'b101;
        req_wr  = 3'b000;
        addr_p[0] = 15'h0050;
        addr_p[2] = 15'h0060;
        #2;
        chk("rst_mid_rdv0", 32'(rr_rdv), 32'h0);
        @(negedge clk);
        #2;
        chk("rst_mid_rdv1", 32'(rr_rdv), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        chk_port("rst_rel_gnt", 0, rr_busy, rr_sen, rr_swr, rr_saddr, rr_sbe, rr_swd);
        chk("rst_rel_rdv", 32'(rr_rdv), 32'h0);
        drive(3'b000, 3'b000, 15'h0, 15'h0, 15'h0);
        chk("rst_post_rdv0", 32'(rr_rdv), 32'h0);
        drive(3'b000, 3'b000, 15'h0, 15'h0, 15'h0);
        chk("rst_post_rdv1", 32'(rr_rdv), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arb.md
Name: sram_port_arb

Overview:
- Parametrised N-port arbiter that lets several single-beat requesters share one single-port synchronous SRAM (CPU IRAM/DRAM, DMA, debug).
- Supports fixed priority with starvation escape, or round-robin.
- Returns read data with a configurable SRAM read latency and per-port rd_valid tagging.
- Sits between the Xtensa local-memory buses and the unified SRAM macro.

Parameters:
- NUM_PORTS, 3, number of requesters (2..8).
- ADDR_W, 15, word address width.
- DATA_W, 32, data width; BE_W = DATA_W/8.
- RD_LAT, 1, SRAM read latency in cycles (1..4).
- ARB_MODE, 0, 0 = fixed priority (port 0 highest), 1 = round-robin.
- STARVE_MAX, 4, fixed mode only: wait cycles before a port is force-granted (1..15).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- req_en  in  NUM_PORTS  access request per port
- req_wr  in  NUM_PORTS  1 = write, 0 = read
- req_addr  in  NUM_PORTS*ADDR_W  packed word addresses, port 0 in LSBs
- req_byteen  in  NUM_PORTS*BE_W  packed byte enables; used for writes
- req_wrdata  in  NUM_PORTS*DATA_W  packed write data
- req_busy  out  NUM_PORTS  request not accepted this cycle
- rd_data  out  DATA_W  read data, shared by all ports
- rd_valid  out  NUM_PORTS  one-hot; rd_data belongs to that port
- sram_en  out  1  SRAM access strobe
- sram_wr  out  1  SRAM write
- sram_addr  out  ADDR_W  SRAM address
- sram_byteen  out  BE_W  SRAM byte enables
- sram_wrdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data

Behaviour:
- Handshake:
  - A request is accepted in any cycle where req_en[i]=1 and req_busy[i]=0.
  - While busy, the requester holds en, wr, addr, byteen and wrdata stable.
  - req_busy[i] = req_en[i] & ~grant[i], combinational, same cycle.
  - Zero-cycle accept: there is no registered grant stage.
- Grant:
  - One-hot combinational function of req_en and the registered state (rr_ptr, wait counters).
  - Exactly one grant whenever any req_en=1; none otherwise.
- SRAM mux:
  - The sram_* outputs take the granted port's fields.
  - sram_byteen is forced to all-ones for reads.
  - With no grant: sram_en=0 and the other sram_* outputs are 0.
- Fixed mode (ARB_MODE=0):
  - Per-port wait_cnt (4 bit) increments each cycle that port is busy, saturating at STARVE_MAX.
  - wait_cnt clears on grant or when req_en drops.
  - Any port with wait_cnt==STARVE_MAX is "starved"; the lowest-index starved port wins.
  - If no port is starved, the lowest-index requester wins.
- Round-robin mode (ARB_MODE=1):
  - The search starts at rr_ptr and wraps modulo NUM_PORTS.
  - After each grant, rr_ptr = granted index + 1, wrapping NUM_PORTS-1 -> 0.
  - rr_ptr holds when idle.
  - wait_cnt is unused and held at 0.
- Read return:
  - RD_LAT-deep shift pipeline of {valid, one-hot port}, loaded on each granted read.
  - rd_valid = last stage, i.e. asserted exactly RD_LAT cycles after the accept cycle.
  - rd_data = sram_rdata, passed through combinationally.
  - Writes load an invalid entry and produce no rd_valid.
  - Back-to-back reads from any ports return in order, one per cycle.
- Writes complete in the accept cycle; no write ack.
- Reset (asynchronous assert, synchronous release):
  - rr_ptr=0, wait_cnt=0, read pipeline cleared, so rd_valid=0.
  - sram_en follows inputs combinationally; it is 0 when all req_en=0.
  - Reset mid-operation: reads in flight are dropped and rd_valid never fires for them.
  - Held requests are re-arbitrated from rr_ptr=0 after release.
- Boundaries:
  - Single requester: never busy.
  - All ports requesting every cycle in RR mode: each port is granted exactly once per NUM_PORTS cycles.
  - In fixed mode, a low-priority port waits at most STARVE_MAX+NUM_PORTS-1 cycles.
  - NUM_PORTS=1: grant=req_en, rr_ptr stays 0.

Test Plan:
- Fixed, RD_LAT=1:
  - Stimulus: port0 read 0x0010 and port1 read 0x0020, same cycle.
  - Required: port0 granted, sram_addr=0x0010, req_busy=3'b010.
  - Next cycle: rd_valid=3'b001, sram_addr=0x0020.
  - Following cycle: rd_valid=3'b010.
- Fixed, STARVE_MAX=4, ports 0 and 2 continuously requesting:
  - Required: port2 busy 4 cycles, granted in cycle 5, then its wait_cnt resets.
  - Port0 is busy only in that cycle.
- RR, NUM_PORTS=3, all ports requesting for 9 cycles:
  - Required: grant sequence 0,1,2,0,1,2,0,1,2 and rr_ptr=0 at the end.
- RD_LAT=3:
  - Stimulus: port1 write 0xDEADBEEF byteen 4'b0011 at addr 0x7FFF, then port1 read of the same address.
  - Required: write drives sram_byteen=4'b0011 with no rd_valid.
  - Read: sram_byteen=4'hF; rd_valid=3'b010 three cycles later, with sram_rdata passed to rd_data.
- Reset mid-read, RD_LAT=2:
  - Stimulus: assert reset_n=0 one cycle after a port0 read accept.
  - Required: rd_valid stays 0; after release, the first grant is port0 (RR: rr_ptr=0).
- Idle:
  - Stimulus: all req_en=0 for 5 cycles.
  - Required: sram_en=0, sram_* outputs=0, req_busy=0, rr_ptr unchanged.
